// File: rtl/hamming_secded_encoder.sv
// hamming_secded_encoder
//   Encoder half of the Hamming SECDED (16,11) scheme. On an accepted req the
//   engine becomes memory master, reads NUM_MSGS 11-bit messages from the
//   byte-wide data memory, inserts parity bits p8/p4/p2/p1 plus overall
//   parity p0, writes the 16-bit codewords back, then raises ack.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req        in   start request, sampled on clock
//   ack        out  done flag (level)
//   mem_addr   out  DM byte address
//   mem_wr_en  out  DM write strobe for the current cycle
//   mem_wdata  out  DM write data
//   mem_rdata  in   DM read data, valid the cycle after mem_addr is presented
//   rsvd_err   out  count of messages with nonzero reserved high-byte bits
//
// Handshake: req is accepted only in IDLE. Accepting it clears ack on the
//   next cycle; ack rises (registered) after the last codeword byte is written
//   and holds until the next accepted req. req seen while busy is ignored.
//
// Build option: define HAMMING_ENC_RSVD_CHK_EN to enable the saturating
//   reserved-bit counter on rsvd_err; otherwise rsvd_err is tied to zero.
//
// Message layout: low byte = d[8:1], high byte = {rsvd[4:0], d[11:9]}.
// Codeword layout: {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}.

module hamming_secded_encoder #(
  parameter int NUM_MSGS = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [3:0]    rsvd_err
);

  localparam int IW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CAP,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    lo_q;
  logic [2:0]    hi_q;
  logic [10:0]   enc_in;
  logic [15:0]   cw;
  logic          last_msg;

  // Byte address of message/codeword i; int arithmetic truncated to AW bits
  // gives the intended modulo-2^AW wrap.
  function automatic logic [AW-1:0] addr_of(input int base, input logic [IW-1:0] i,
                                            input logic hi);
    return AW'(base + 2 * int'(i) + int'(hi));
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [11:1] d;
    logic        p8, p4, p2, p1, p0;
    d  = m;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  // The low codeword byte is registered onto mem_wdata on the same edge that
  // captures the high message byte, so in CAP the encoder takes the high bits
  // straight from mem_rdata; afterwards it uses the captured copy.
  always_comb begin
    enc_in = (state == S_CAP) ? {mem_rdata[2:0], lo_q} : {hi_q, lo_q};
    cw     = encode(enc_in);
  end

  assign last_msg = (idx == IW'(NUM_MSGS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ack       <= 1'b0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
      idx       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            ack      <= 1'b0;
            idx      <= '0;
            mem_addr <= addr_of(SRC_BASE, '0, 1'b0);
            state    <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          mem_addr <= addr_of(SRC_BASE, idx, 1'b1);
          state    <= S_RD_HI;
        end
        S_RD_HI: begin
          lo_q  <= mem_rdata;
          state <= S_CAP;
        end
        S_CAP: begin
          hi_q      <= mem_rdata[2:0];
          mem_addr  <= addr_of(DST_BASE, idx, 1'b0);
          mem_wr_en <= 1'b1;
          mem_wdata <= cw[7:0];
          state     <= S_WR_LO;
        end
        S_WR_LO: begin
          mem_addr  <= addr_of(DST_BASE, idx, 1'b1);
          mem_wr_en <= 1'b1;
          mem_wdata <= cw[15:8];
          state     <= S_WR_HI;
        end
        S_WR_HI: begin
          if (last_msg) begin
            mem_addr <= '0;
            state    <= S_DONE;
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= addr_of(SRC_BASE, idx + 1'b1, 1'b0);
            state    <= S_RD_LO;
          end
        end
        S_DONE: begin
          ack   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HAMMING_ENC_RSVD_CHK_EN
  logic [3:0] rsvd_q;

  // Counts messages whose high byte carries reserved bits; saturates at 15.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsvd_q <= '0;
    end else if (state == S_IDLE && req) begin
      rsvd_q <= '0;
    end else if (state == S_CAP && (|mem_rdata[7:3]) && rsvd_q != 4'hF) begin
      rsvd_q <= rsvd_q + 4'd1;
    end
  end

  assign rsvd_err = rsvd_q;
`else
  logic unused_rsvd_bits;

  // Reserved high-byte bits play no part in encoding in this build.
  assign unused_rsvd_bits = ^mem_rdata[7:3];
  assign rsvd_err         = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_encoder.sv
module tb_hamming_secded_encoder;

  localparam int NUM_MSGS = 15;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 30;
  localparam int AW       = 8;
  localparam int ACK_LAT  = 76;
  localparam int LIMIT    = 300;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic          req;
  logic          ack;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [3:0]    rsvd_err;

  always #5 clock = ~clock;

  hamming_secded_encoder #(
    .NUM_MSGS(NUM_MSGS),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE),
    .AW(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .ack(ack),
    .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsvd_err(rsvd_err)
  );

  // ---------------- data memory model (registered read) ----------------
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [7:0]    tb_wdata;
  logic [7:0]    dm [256];

  always @(posedge clock) begin
    if (tb_we) dm[tb_addr] <= tb_wdata;
    else if (mem_wr_en) dm[mem_addr] <= mem_wdata;
    mem_rdata <= dm[mem_addr];
  end

  // ---------------- stimulus state / scoreboard ----------------
  logic [10:0] msg_arr  [NUM_MSGS];
  logic [4:0]  rsvd_arr [NUM_MSGS];
  logic [23:0] exp_q[$];   // {codeword low-byte address, codeword}
  logic [23:0] got_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference encoder built from Hamming positions: data fills the
  // non-power-of-two positions 1..15, parity at 2^j covers positions with bit j.
  function automatic logic [15:0] model_cw(input logic [10:0] m);
    logic [15:0] c;
    logic        p;
    int          k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = m[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (((pos >> j) & 1) != 0) p = p ^ c[pos];
      c[1 << j] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Decoder view: {syndrome, overall parity, extracted data}.
  function automatic logic [15:0] decode(input logic [15:0] c);
    logic [3:0]  s;
    logic [10:0] d;
    int          k;
    s = '0;
    d = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if (c[pos]) s = s ^ 4'(pos);
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos];
        k++;
      end
    end
    return {s, ^c, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_byte(input int a, input logic [7:0] d);
    @(negedge clock);
    tb_we    = 1'b1;
    tb_addr  = AW'(a);
    tb_wdata = d;
    @(negedge clock);
    tb_we    = 1'b0;
  endtask

  task automatic randomize_msgs();
    for (int i = 0; i < NUM_MSGS; i++) begin
      msg_arr[i]  = 11'($urandom_range(0, 2047));
      rsvd_arr[i] = '0;
    end
  endtask

  task automatic preload();
    for (int i = 0; i < NUM_MSGS; i++) begin
      write_byte(SRC_BASE + 2 * i,     msg_arr[i][7:0]);
      write_byte(SRC_BASE + 2 * i + 1, {rsvd_arr[i], msg_arr[i][10:8]});
      write_byte(DST_BASE + 2 * i,     8'hA5);
      write_byte(DST_BASE + 2 * i + 1, 8'h5A);
    end
  endtask

  task automatic push_expected();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < NUM_MSGS; i++)
      exp_q.push_back({AW'(DST_BASE + 2 * i), model_cw(msg_arr[i])});
  endtask

  // Pulses req, then collects codeword writes until ack or the cycle budget.
  // cycles counts clock edges from the one that sampled req.
  task automatic run_encode(input bit mid_pulse, output int cycles,
                            output logic ack_at_start, output int n_writes);
    logic          have_lo;
    logic [AW-1:0] lo_addr;
    logic [7:0]    lo_byte;
    have_lo  = 1'b0;
    lo_addr  = '0;
    lo_byte  = '0;
    n_writes = 0;
    @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req          = 1'b0;
    cycles       = 0;
    ack_at_start = ack;
    while (ack !== 1'b1 && cycles < LIMIT) begin
      if (mem_wr_en === 1'b1) begin
        n_writes++;
        if (!have_lo) begin
          lo_addr = mem_addr;
          lo_byte = mem_wdata;
          have_lo = 1'b1;
        end else begin
          got_q.push_back({lo_addr, mem_wdata, lo_byte});
          have_lo = 1'b0;
        end
      end
      req = (mid_pulse && cycles == 20);
      @(negedge clock);
      cycles++;
    end
    req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
    repeat (3) @(negedge clock);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %h expected 00", mem_wdata); end
    checks++; if (rsvd_err !== 4'h0) begin failures++; $display("FAIL reset_rsvd: got %h expected 0", rsvd_err); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (ack !== 1'b0 || mem_wr_en !== 1'b0) begin failures++; $display("FAIL idle_after_reset: got ack=%b wr=%b expected 0/0", ack, mem_wr_en); end
  endtask

  task automatic test_zero();
    int cyc, nw; logic a0; logic [23:0] e, g;
    for (int i = 0; i < NUM_MSGS; i++) begin msg_arr[i] = '0; rsvd_arr[i] = '0; end
    preload();
    push_expected();
    run_encode(1'b0, cyc, a0, nw);
    checks++; if (cyc != ACK_LAT) begin failures++; $display("FAIL zero_latency: got %0d expected %0d", cyc, ACK_LAT); end
    checks++; if (nw != 2 * NUM_MSGS) begin failures++; $display("FAIL zero_write_count: got %0d expected %0d", nw, 2 * NUM_MSGS); end
    checks++; if (dm[30] !== 8'h00) begin failures++; $display("FAIL zero_dm30: got %h expected 00", dm[30]); end
    checks++; if (dm[31] !== 8'h00) begin failures++; $display("FAIL zero_dm31: got %h expected 00", dm[31]); end
    for (int i = 0; i < NUM_MSGS; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL zero_cw[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_known();
    int cyc, nw; logic a0; logic [23:0] e, g;
    logic [15:0] known [3];
    randomize_msgs();
    msg_arr[0] = 11'h7FF; msg_arr[1] = 11'h001; msg_arr[2] = 11'h400;
    known[0] = 16'hFFFF; known[1] = 16'h000F; known[2] = 16'h8117;
    preload();
    push_expected();
    run_encode(1'b0, cyc, a0, nw);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dm[DST_BASE + 2 * i + 1], dm[DST_BASE + 2 * i]} !== known[i]) begin
        failures++;
        $display("FAIL known_cw[%0d]: got %h expected %h", i, {dm[DST_BASE + 2 * i + 1], dm[DST_BASE + 2 * i]}, known[i]);
      end
    end
    for (int i = 0; i < NUM_MSGS; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL known_sb[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_random();
    int cyc, nw; logic a0; logic [23:0] e, g; logic [7:0] src;
    randomize_msgs();
    preload();
    push_expected();
    run_encode(1'b0, cyc, a0, nw);
    checks++; if (cyc != ACK_LAT) begin failures++; $display("FAIL random_latency: got %0d expected %0d", cyc, ACK_LAT); end
    for (int i = 0; i < NUM_MSGS; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL random_cw[%0d]: got %h expected %h", i, g, e); end
      checks++;
      if (decode({dm[DST_BASE + 2 * i + 1], dm[DST_BASE + 2 * i]}) !== {4'h0, 1'b0, msg_arr[i]}) begin
        failures++;
        $display("FAIL random_decode[%0d]: got %h expected %h", i,
                 decode({dm[DST_BASE + 2 * i + 1], dm[DST_BASE + 2 * i]}), {4'h0, 1'b0, msg_arr[i]});
      end
    end
    for (int a = 0; a < 2 * NUM_MSGS; a++) begin
      src = (a % 2 == 0) ? msg_arr[a / 2][7:0] : {rsvd_arr[a / 2], msg_arr[a / 2][10:8]};
      checks++; if (dm[SRC_BASE + a] !== src) begin failures++; $display("FAIL random_src[%0d]: got %h expected %h", a, dm[SRC_BASE + a], src); end
    end
  endtask

  task automatic test_busy_req();
    int cyc, nw; logic a0; logic [23:0] e, g;
    randomize_msgs();
    preload();
    push_expected();
    run_encode(1'b1, cyc, a0, nw);
    checks++; if (cyc != ACK_LAT) begin failures++; $display("FAIL busy_latency: got %0d expected %0d", cyc, ACK_LAT); end
    checks++; if (nw != 2 * NUM_MSGS) begin failures++; $display("FAIL busy_write_count: got %0d expected %0d", nw, 2 * NUM_MSGS); end
    for (int i = 0; i < NUM_MSGS; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL busy_cw[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nw; logic a0;
    repeat (3) @(negedge clock);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL b2b_ack_held: got %b expected 1", ack); end
    push_expected();
    run_encode(1'b0, cyc, a0, nw);
    checks++; if (a0 !== 1'b0) begin failures++; $display("FAIL b2b_ack_drop: got %b expected 0", a0); end
    checks++; if (cyc != ACK_LAT) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, ACK_LAT); end
    checks++; if (got_q.size() != NUM_MSGS) begin failures++; $display("FAIL b2b_cw_count: got %0d expected %0d", got_q.size(), NUM_MSGS); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, nw, n; logic a0; logic [23:0] e, g;
    randomize_msgs();
    preload();
    @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    n = 0;
    while (!(mem_wr_en === 1'b1 && mem_addr === AW'(DST_BASE + 14)) && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    checks++; if (n >= LIMIT) begin failures++; $display("FAIL midrst_reach_wr_lo7: got timeout after %0d cycles expected write to %0d", n, DST_BASE + 14); end
    reset = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL midrst_ack: got %b expected 0", ack); end
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL midrst_wr_en: got %b expected 0", mem_wr_en); end
    @(negedge clock);
    reset = 1'b0;
    push_expected();
    run_encode(1'b0, cyc, a0, nw);
    checks++; if (cyc != ACK_LAT) begin failures++; $display("FAIL midrst_latency: got %0d expected %0d", cyc, ACK_LAT); end
    for (int i = 0; i < NUM_MSGS; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL midrst_cw[%0d]: got %h expected %h", i, g, e); end
      checks++;
      if ({dm[DST_BASE + 2 * i + 1], dm[DST_BASE + 2 * i]} !== e[15:0]) begin
        failures++;
        $display("FAIL midrst_dm[%0d]: got %h expected %h", i, {dm[DST_BASE + 2 * i + 1], dm[DST_BASE + 2 * i]}, e[15:0]);
      end
    end
  endtask

  task automatic test_rsvd();
    int cyc, nw; logic a0; logic [23:0] e, g; logic [3:0] exp_rsvd;
`ifdef HAMMING_ENC_RSVD_CHK_EN
    exp_rsvd = 4'd3;
`else
    exp_rsvd = 4'd0;
`endif
    randomize_msgs();
    rsvd_arr[2] = 5'h1F; rsvd_arr[5] = 5'h1F; rsvd_arr[9] = 5'h1F;
    preload();
    push_expected();
    run_encode(1'b0, cyc, a0, nw);
    checks++; if (rsvd_err !== exp_rsvd) begin failures++; $display("FAIL rsvd_count: got %0d expected %0d", rsvd_err, exp_rsvd); end
    for (int i = 0; i < NUM_MSGS; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++; if (g !== e) begin failures++; $display("FAIL rsvd_cw[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero();
    test_known();
    test_random();
    test_busy_req();
    test_back_to_back();
    test_reset_mid_run();
    test_rsvd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
